// File: rtl/addsub_pkg.sv
// Shared types and defaults for the multi-cycle adder/subtractor.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry slice, time-multiplexed by seq_addsub_unit.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = i_cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_carry[CHUNK];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock, valid/ready on both sides, NZCV flags.
// Optional signed saturation is compiled in with `define ADDSUB_SAT_EN.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  generate
    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("seq_addsub_unit: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CNT_W-1:0] r_k;
  flags_t           r_flags;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_overflow;
  logic [WIDTH-1:0] w_result_next;
  logic [WIDTH-1:0] w_final;
  flags_t           w_flags;

`ifdef ADDSUB_SAT_EN
  logic r_sat;
`else
  logic w_sat_unused;
  assign w_sat_unused = sat;
`endif

  assign w_last = (r_k == LAST_K);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand slice selected by the chunk counter feeds the single shared adder slice.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == CNT_W'(i)) begin
        w_a_slice = r_a[i*CHUNK +: CHUNK];
        w_b_slice = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice_wr
      assign w_result_next[gi*CHUNK +: CHUNK] =
        (r_k == CNT_W'(gi)) ? w_sum : r_result[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // r_b already holds the effective (possibly inverted) operand.
  assign w_overflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_result_next[WIDTH-1] != r_a[WIDTH-1]);

  always_comb begin
    w_final = w_result_next;
`ifdef ADDSUB_SAT_EN
    if (r_sat && w_overflow) begin
      w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    w_flags   = '0;
    w_flags.c = w_cout;
    w_flags.z = (w_final == '0);
    w_flags.n = w_final[WIDTH-1];
    w_flags.v = w_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_flags  <= '0;
`ifdef ADDSUB_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= sub ? ~b : b;
            r_carry  <= sub;
            r_k      <= '0;
            r_result <= '0;
            r_flags  <= '0;
`ifdef ADDSUB_SAT_EN
            r_sat    <= sat;
`endif
          end
        end
        CALC: begin
          r_carry <= w_cout;
          r_k     <= r_k + CNT_W'(1);
          if (w_last) begin
            r_result <= w_final;
            r_flags  <= w_flags;
          end else begin
            r_result <= w_result_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign out_valid     = (r_state == DONE);
  assign result        = r_result;
  assign carry_flag    = r_flags.c;
  assign zero_flag     = r_flags.z;
  assign negative_flag = r_flags.n;
  assign overflow_flag = r_flags.v;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Bench for seq_addsub_unit: directed vectors on 32/8, random ops on 32/32 and 16/4 against a model.
module tb_seq_addsub_unit;

  typedef longint unsigned u64_t;
  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance 32/8
  logic        m_in_valid, m_in_ready, m_sub, m_sat, m_out_valid, m_out_ready, m_busy;
  logic        m_c, m_z, m_n, m_v;
  logic [31:0] m_a, m_b, m_result;
  // single-slice instance 32/32
  logic        p_in_valid, p_in_ready, p_sub, p_sat, p_out_valid, p_out_ready, p_busy;
  logic        p_c, p_z, p_n, p_v;
  logic [31:0] p_a, p_b, p_result;
  // narrow instance 16/4
  logic        q_in_valid, q_in_ready, q_sub, q_sat, q_out_valid, q_out_ready, q_busy;
  logic        q_c, q_z, q_n, q_v;
  logic [15:0] q_a, q_b, q_result;

  exp_t exp_m[$];
  exp_t exp_p[$];
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [31:0] SAT_POS_R = 32'h7FFFFFFF;
  localparam logic [3:0]  SAT_POS_F = 4'b0001;
  localparam logic [31:0] SAT_NEG_R = 32'h80000000;
  localparam logic [3:0]  SAT_NEG_F = 4'b1011;
`else
  localparam logic [31:0] SAT_POS_R = 32'h80000098;
  localparam logic [3:0]  SAT_POS_F = 4'b0011;
  localparam logic [31:0] SAT_NEG_R = 32'h7FFFFFFF;
  localparam logic [3:0]  SAT_NEG_F = 4'b1001;
`endif

  seq_addsub_unit #(.WIDTH(32), .CHUNK(8)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .sub(m_sub), .sat(m_sat),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_result),
    .carry_flag(m_c), .zero_flag(m_z), .negative_flag(m_n), .overflow_flag(m_v),
    .busy(m_busy)
  );

  seq_addsub_unit #(.WIDTH(32), .CHUNK(32)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .sub(p_sub), .sat(p_sat),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .result(p_result),
    .carry_flag(p_c), .zero_flag(p_z), .negative_flag(p_n), .overflow_flag(p_v),
    .busy(p_busy)
  );

  seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .a(q_a), .b(q_b), .sub(q_sub), .sat(q_sat),
    .out_valid(q_out_valid), .out_ready(q_out_ready), .result(q_result),
    .carry_flag(q_c), .zero_flag(q_z), .negative_flag(q_n), .overflow_flag(q_v),
    .busy(q_busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on w-bit operands, flags from signed/unsigned ranges.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic st);
    exp_t e;
    u64_t mask, ua, ub, full, r;
    longint sa, sb, ex, maxv, minv;
    logic c, v;
    mask = (u64_t'(1) << w) - u64_t'(1);
    ua   = u64_t'(a) & mask;
    ub   = u64_t'(b) & mask;
    full = s ? (ua + (~ub & mask) + u64_t'(1)) : (ua + ub);
    c    = ((full >> w) & u64_t'(1)) != 0;
    r    = full & mask;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -maxv - 1;
    sa   = (longint'(ua) > maxv) ? longint'(ua) - 2 * (maxv + 1) : longint'(ua);
    sb   = (longint'(ub) > maxv) ? longint'(ub) - 2 * (maxv + 1) : longint'(ub);
    ex   = s ? (sa - sb) : (sa + sb);
    v    = (ex > maxv) || (ex < minv);
`ifdef ADDSUB_SAT_EN
    if (st && v) r = u64_t'((ex > 0) ? maxv : minv) & mask;
`else
    if (st && 1'b0) r = 0;
`endif
    e.r = r[31:0];
    e.f = {c, (r == 0), (((r >> (w - 1)) & u64_t'(1)) != 0), v};
    return e;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] half, mask, x;
    half = 32'h1 << (w - 1);
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    case ($urandom_range(0, 3))
      0:       x = $urandom;
      1:       x = half - 32'h1 - 32'($urandom_range(0, 255));
      2:       x = half + 32'($urandom_range(0, 255));
      default: x = 32'($urandom_range(0, 3));
    endcase
    return x & mask;
  endfunction

  // Single compare process: every cycle a result is presented it must match the model queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_out_valid) begin
        if (exp_m.size() == 0) begin
          tests++; fails++;
          $display("FAIL main unexpected out_valid: got 1 expected 0");
        end else begin
          check("main result", m_result, exp_m[0].r);
          check("main flags", 32'({m_c, m_z, m_n, m_v}), 32'(exp_m[0].f));
          check("main in_ready in DONE", 32'(m_in_ready), 32'd0);
          check("main busy in DONE", 32'(m_busy), 32'd1);
          if (m_out_ready) void'(exp_m.pop_front());
        end
      end
      if (p_out_valid) begin
        if (exp_p.size() == 0) begin
          tests++; fails++;
          $display("FAIL n1 unexpected out_valid: got 1 expected 0");
        end else begin
          check("n1 result", p_result, exp_p[0].r);
          check("n1 flags", 32'({p_c, p_z, p_n, p_v}), 32'(exp_p[0].f));
          if (p_out_ready) void'(exp_p.pop_front());
        end
      end
      if (q_out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL w16 unexpected out_valid: got 1 expected 0");
        end else begin
          check("w16 result", {16'h0, q_result}, exp_q[0].r);
          check("w16 flags", 32'({q_c, q_z, q_n, q_v}), 32'(exp_q[0].f));
          if (q_out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic main_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic ts, input logic tsat,
                         input logic [31:0] er, input logic [3:0] ef, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!m_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, " in_ready before issue"}, 32'(m_in_ready), 32'd1);
    e = model(32, ta, tb, ts, tsat);
    check({name, " model result"}, e.r, er);
    check({name, " model flags"}, 32'(e.f), 32'(ef));
    m_a = ta; m_b = tb; m_sub = ts; m_sat = tsat; m_in_valid = 1'b1;
    @(posedge clk);
    exp_m.push_back(e);
    #1;
    m_in_valid = 1'b0;
    m_a = ~ta; m_b = ta ^ tb; m_sub = ~ts; m_sat = ~tsat;
    n = 0;
    while (!m_out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, " latency"}, 32'(n), 32'd4);
    check({name, " result"}, m_result, er);
    check({name, " flags"}, 32'({m_c, m_z, m_n, m_v}), 32'(ef));
    repeat (hold) begin
      @(posedge clk); #1;
      check({name, " stall in_ready"}, 32'(m_in_ready), 32'd0);
      check({name, " stall result"}, m_result, er);
    end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    check({name, " in_ready after handshake"}, 32'(m_in_ready), 32'd1);
    check({name, " out_valid after handshake"}, 32'(m_out_valid), 32'd0);
    $display("[TB] %s a=%h b=%h sub=%0d sat=%0d -> %h cznv=%b", name, ta, tb, ts, tsat, m_result,
             {m_c, m_z, m_n, m_v});
  endtask

  task automatic rand_n1();
    int n;
    exp_t e;
    logic [31:0] ra, rb;
    logic rs, rt;
    for (int i = 0; i < 1000; i++) begin
      ra = pick(32); rb = pick(32);
      rs = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
      e = model(32, ra, rb, rs, rt);
      p_a = ra; p_b = rb; p_sub = rs; p_sat = rt; p_in_valid = 1'b1;
      @(posedge clk);
      exp_p.push_back(e);
      #1;
      p_in_valid = 1'b0; p_a = $urandom; p_b = $urandom; p_sub = ~rs;
      n = 0;
      while (!p_out_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("n1 latency", 32'(n), 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      p_out_ready = 1'b1;
      @(posedge clk); #1;
      p_out_ready = 1'b0;
    end
  endtask

  task automatic rand_w16();
    int n;
    exp_t e;
    logic [31:0] ra, rb;
    logic rs, rt;
    for (int i = 0; i < 1000; i++) begin
      ra = pick(16); rb = pick(16);
      rs = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
      e = model(16, ra, rb, rs, rt);
      q_a = ra[15:0]; q_b = rb[15:0]; q_sub = rs; q_sat = rt; q_in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      q_in_valid = 1'b0; q_a = 16'($urandom); q_b = 16'($urandom); q_sub = ~rs;
      n = 0;
      while (!q_out_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("w16 latency", 32'(n), 32'd4);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      q_out_ready = 1'b1;
      @(posedge clk); #1;
      q_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_in_valid = 0; m_a = 0; m_b = 0; m_sub = 0; m_sat = 0; m_out_ready = 0;
    p_in_valid = 0; p_a = 0; p_b = 0; p_sub = 0; p_sat = 0; p_out_ready = 0;
    q_in_valid = 0; q_a = 0; q_b = 0; q_sub = 0; q_sat = 0; q_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(m_out_valid), 32'd0);
    check("reset busy", 32'(m_busy), 32'd0);
    check("reset in_ready", 32'(m_in_ready), 32'd1);
    check("reset result", m_result, 32'd0);
    check("reset flags", 32'({m_c, m_z, m_n, m_v}), 32'd0);
    check("reset n1 in_ready", 32'(p_in_ready), 32'd1);
    check("reset w16 out_valid", 32'(q_out_valid), 32'd0);
    rst = 1'b0;

    main_op("add_wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1100, 0);
    main_op("sub_100_40",   32'd100,      32'd40,       1'b1, 1'b0, 32'h0000003C, 4'b1000, 0);
    main_op("sub_3_10",     32'd3,        32'd10,       1'b1, 1'b0, 32'hFFFFFFF9, 4'b0010, 0);
    main_op("add_ovf_wrap", 32'h7FFFFFD0, 32'h000000C8, 1'b0, 1'b0, 32'h80000098, 4'b0011, 0);
    main_op("add_ovf_sat",  32'h7FFFFFD0, 32'h000000C8, 1'b0, 1'b1, SAT_POS_R,    SAT_POS_F, 5);
    main_op("b2b_sub_min",  32'h00000000, 32'h80000000, 1'b1, 1'b0, 32'h80000000, 4'b0011, 0);
    main_op("sub_neg_sat",  32'h80000000, 32'h00000001, 1'b1, 1'b1, SAT_NEG_R,    SAT_NEG_F, 2);
    main_op("sub_equal",    32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 4'b1100, 0);

    // Abort an in-flight SUB after two slices; no result may ever appear for it.
    m_a = 32'd55; m_b = 32'd55; m_sub = 1'b1; m_sat = 1'b0; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort busy before reset", 32'(m_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(m_out_valid), 32'd0);
    check("abort busy", 32'(m_busy), 32'd0);
    check("abort in_ready", 32'(m_in_ready), 32'd1);
    check("abort result", m_result, 32'd0);
    check("abort flags", 32'({m_c, m_z, m_n, m_v}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort no out_valid", 32'(m_out_valid), 32'd0);
    $display("[TB] abort sub 55-55 after 2 slices -> idle");
    main_op("add_25_17",    32'd25,       32'd17,       1'b0, 1'b0, 32'h0000002A, 4'b0000, 0);

    fork
      rand_n1();
      rand_w16();
    join
    $display("[TB] random: 1000 ops on 32/32 and 1000 ops on 16/4 done");
    check("n1 queue drained", 32'(exp_p.size()), 32'd0);
    check("w16 queue drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
